line_memory: RTL and testbench
==============================

Name: line_memory

Overview:
- Line-granular backing data memory that sits directly downstream of the data cache.
- Serves 256-bit (32-byte) line reads and write-backs over the enable/write/ack handshake.
- Fixed, parameterised access latency models main-memory delay, so the cache miss and write-back paths can be exercised cycle-accurately.
- One outstanding request at a time.

Parameters:
- LATENCY, 10, cycles from request acceptance to ack_o; legal range 1..255.
- IDX_W, 9, line-index width; storage depth is 2**IDX_W lines of 256 bits.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  request valid; held by the requester until it samples ack_o.
- write_i  in  1  1 = line write, 0 = line read; qualified by enable_i.
- addr_i  in  32  byte address; bits [4:0] ignored; line index = addr_i[IDX_W+4:5]; higher bits ignored, so addresses alias.
- data_i  in  256  write line; bit 0 = byte 0 of the line.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line; valid in the ack_o cycle and held afterwards.
- err_o  out  1  sticky protocol error; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst_i low:
  - state = IDLE, counter = 0, ack_o = 0, data_o = 0, err_o = 0.
  - Any in-flight request is dropped and no array write occurs.
  - Array contents are not cleared; contents are unspecified at power-up.
- States:
  - IDLE:
    - On a rising edge with enable_i = 1, latch addr index, write_i and data_i; load counter = LATENCY-1.
    - Go to BUSY, or directly to ACK when LATENCY = 1.
  - BUSY:
    - Decrement the counter each cycle.
    - When the counter reaches 1, go to ACK on the next edge.
    - Inputs are not re-sampled; the latched request is used.
  - ACK:
    - ack_o = 1 for exactly this one cycle.
    - Write: the array line is updated at the edge ending ACK.
    - Read: data_o is loaded from the array at the edge entering ACK.
    - Always go to IDLE next; enable_i is ignored during ACK.
- Latency: accepting edge at cycle 0; ack_o high during cycle LATENCY.
- Back-to-back requests:
  - The requester sees ack_o at the edge ending ACK and may change or keep enable_i.
  - IDLE samples the new value one cycle later.
  - Minimum request spacing is therefore LATENCY+1 cycles.
  - A write-back followed immediately by a refill read (enable_i held high, write_i dropped) is legal and is accepted at the first IDLE edge.
- data_o:
  - Changes only when a read enters ACK.
  - Writes never alter data_o.
  - The requester may consume data_o in any cycle after ack_o until its next read completes.
- enable_i deasserted during BUSY: the transaction still completes (write performed, ack_o pulsed).
- Read of a line written by the previous transaction returns the new data; no bypass hazard, because the write is committed before IDLE.

Optional Feature:
- Macro LINE_MEMORY_PROTO_CHK_EN.
- Defined:
  - err_o is set, and held until reset, if during BUSY any of enable_i = 0, write_i changed, or addr_i[IDX_W+4:5] changed versus the latched value.
  - Also under simulation, a $display message naming the cycle and condition.
- Undefined: err_o is tied to 0 and no checking logic is built.
- Transaction behaviour is identical with and without the macro.

Test Plan:
- Write then read: write data_i = {8{32'hA5A5_0000 + i}} at addr 0x0000_0400, then read 0x0000_0400 -> each ack_o exactly 10 cycles after acceptance; read data_o equals the written line.
- Back-to-back: write 0x0000_0800 with enable_i held high, switching write_i to 0 in the cycle after ack_o -> second ack_o arrives 11 cycles after the first; data_o equals the line written.
- Aliasing: write line X to 0x0000_401F, read 0x0000_4000 and 0x0000_C000 (index wrap with IDX_W = 9) -> both reads return X.
- Reset mid-BUSY: start a write of 256'h1 to 0x20 over previous content 256'h0, pull rst_i low in cycle 5 -> ack_o never pulses; a subsequent read of 0x20 returns 256'h0; data_o = 0 right after reset.
- Hold: after a read ack with data_o = D, deassert enable_i for 3 cycles, then do a write of other data -> data_o stays D throughout.
- With LINE_MEMORY_PROTO_CHK_EN: drop enable_i in cycle 3 of BUSY -> err_o = 1 from the next cycle and held; ack_o still pulses in cycle 10. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/line_memory.sv
// Line-granular backing memory behind the data cache: 256-bit lines, fixed LATENCY, one request in flight.
// Optional protocol checker enabled by defining LINE_MEMORY_PROTO_CHK_EN (drives the sticky err_o).
module line_memory #(
    parameter int LATENCY = 10,
    parameter int IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [255:0]       r_wdata;
    logic               r_ack;
    logic [255:0]       r_rdata;
    logic [255:0]       r_mem [0:(1<<IDX_W)-1];

    logic [IDX_W-1:0]   w_idx;
    logic               w_unused_addr;

    // Offset bits and bits above the index are ignored, so addresses alias.
    assign w_idx         = addr_i[IDX_W+4:5];
    assign w_unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_idx   <= w_idx;
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_cnt   <= LAT_M1;
                        if (LATENCY == 1) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            if (!write_i) begin
                                r_rdata <= r_mem[w_idx];
                            end
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    // Read data is captured on the edge entering ACK so it lines up with ack_o.
                    if (r_cnt == 8'd1) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= r_mem[r_idx];
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write commits on the edge leaving ACK; an asynchronous reset during ACK cancels it.
    always_ff @(posedge clk_i) begin
        if (r_state == S_ACK && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_rdata;

`ifdef LINE_MEMORY_PROTO_CHK_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (r_state == S_BUSY &&
                     (!enable_i || write_i != r_write || w_idx != r_idx)) begin
            r_err <= 1'b1;
`ifndef SYNTHESIS
            $display("line_memory: protocol error at %0t: enable=%0b write=%0b/%0b idx=%0h/%0h",
                     $time, enable_i, write_i, r_write, w_idx, r_idx);
`endif
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed scenarios plus randomized traffic against a line-array model.
module tb_line_memory;

    localparam int LAT   = 10;
    localparam int IDX_W = 9;

    logic         clk      = 1'b0;
    logic         rst_i    = 1'b1;
    logic         enable_i = 1'b0;
    logic         write_i  = 1'b0;
    logic [31:0]  addr_i   = '0;
    logic [255:0] data_i   = '0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    line_memory #(.LATENCY(LAT), .IDX_W(IDX_W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    logic [255:0] model [int];
    logic [255:0] exp_dout = '0;
    int last_ack_edge = 0;
    logic exp_err = 1'b0;

    function automatic int line_of(input logic [31:0] a);
        return int'(a[IDX_W+4:5]);
    endfunction

    // One requester transaction; starts and ends on a falling edge with the DUT idle.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                          input bit chain, input int drop_at);
        int acc;
        int lat;
        bit got;
        int idx;
        idx      = line_of(a);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        acc      = cyc + 1;
        got      = 1'b0;
        for (int k = 1; k <= 300 && !got; k++) begin
            @(negedge clk);
            if (k == drop_at) enable_i = 1'b0;
            if (ack_o === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL ack_timeout: ack_o not seen in 300 cycles, required within %0d", LAT);
        else passes++;
        lat = cyc + 1 - acc;
        checks++;
        if (lat !== LAT) $display("FAIL latency: got %0d cycles, required %0d", lat, LAT);
        else passes++;
        if (!wr && model.exists(idx)) exp_dout = model[idx];
        checks++;
        if (data_o !== exp_dout) $display("FAIL data_o_at_ack: got %h required %h", data_o, exp_dout);
        else passes++;
        if (wr) model[idx] = d;
        last_ack_edge = cyc + 1;
        $display("txn %s addr=%h line=%0d latency=%0d data_o=%h", wr ? "WR" : "RD", a, idx, lat, data_o);
        @(negedge clk);
        checks++;
        if (ack_o !== 1'b0) $display("FAIL ack_pulse_width: ack_o=%b after ACK cycle, required 0", ack_o);
        else passes++;
        if (!chain) enable_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) $display("FAIL reset_ctrl: ack=%b err=%b required 0 0", ack_o, err_o);
        else passes++;
        checks++;
        if (data_o !== '0) $display("FAIL reset_data: data_o=%h required 0", data_o);
        else passes++;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [255:0] line;
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        do_txn(1'b1, 32'h0000_0400, line, 1'b0, 0);
        do_txn(1'b0, 32'h0000_0400, '0, 1'b0, 0);
        checks++;
        if (data_o !== line) $display("FAIL write_read: data_o=%h required %h", data_o, line);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [255:0] line;
        int e1;
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_txn(1'b1, 32'h0000_0800, line, 1'b1, 0);
        e1 = last_ack_edge;
        do_txn(1'b0, 32'h0000_0800, '0, 1'b0, 0);
        checks++;
        if (last_ack_edge - e1 !== LAT + 1)
            $display("FAIL b2b_spacing: got %0d cycles between acks, required %0d", last_ack_edge - e1, LAT + 1);
        else passes++;
        checks++;
        if (data_o !== line) $display("FAIL b2b_data: data_o=%h required %h", data_o, line);
        else passes++;
    endtask

    task automatic test_alias();
        logic [255:0] x;
        x = {8{$urandom}};
        do_txn(1'b1, 32'h0000_401F, x, 1'b0, 0);
        do_txn(1'b0, 32'h0000_4000, '0, 1'b0, 0);
        checks++;
        if (data_o !== x) $display("FAIL alias_4000: data_o=%h required %h", data_o, x);
        else passes++;
        do_txn(1'b0, 32'h0000_C000, '0, 1'b0, 0);
        checks++;
        if (data_o !== x) $display("FAIL alias_C000: data_o=%h required %h", data_o, x);
        else passes++;
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        do_txn(1'b1, 32'h0000_0020, '0, 1'b0, 0);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_0020;
        data_i   = 256'h1;
        repeat (5) @(negedge clk);
        rst_i = 1'b0;
        #1;
        exp_dout = '0;
        exp_err  = 1'b0;
        checks++;
        if (ack_o !== 1'b0 || data_o !== '0 || err_o !== 1'b0)
            $display("FAIL reset_mid_busy: ack=%b err=%b data_o=%h required 0 0 0", ack_o, err_o, data_o);
        else passes++;
        @(negedge clk);
        enable_i = 1'b0;
        rst_i    = 1'b1;
        seen     = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ack_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL dropped_ack: ack_o pulsed after reset, required none");
        else passes++;
        do_txn(1'b0, 32'h0000_0020, '0, 1'b0, 0);
        checks++;
        if (data_o !== '0) $display("FAIL reset_no_write: data_o=%h required 0", data_o);
        else passes++;
    endtask

    task automatic test_hold();
        logic [255:0] d;
        d = exp_dout;
        do_txn(1'b0, 32'h0000_0400, '0, 1'b0, 0);
        d = exp_dout;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (data_o !== d) $display("FAIL hold_idle: data_o=%h required %h", data_o, d);
            else passes++;
        end
        do_txn(1'b1, 32'h0000_1000, ~d, 1'b0, 0);
        checks++;
        if (data_o !== d) $display("FAIL hold_after_write: data_o=%h required %h", data_o, d);
        else passes++;
    endtask

    task automatic test_enable_drop();
        logic [255:0] d;
`ifdef LINE_MEMORY_PROTO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_txn(1'b1, 32'h0000_3000, d, 1'b0, 3);
        checks++;
        if (err_o !== exp_err) $display("FAIL err_after_drop: err_o=%b required %b", err_o, exp_err);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (err_o !== exp_err) $display("FAIL err_sticky: err_o=%b required %b", err_o, exp_err);
        else passes++;
        do_txn(1'b0, 32'h0000_3000, '0, 1'b0, 0);
        checks++;
        if (data_o !== d) $display("FAIL drop_write_done: data_o=%h required %h", data_o, d);
        else passes++;
    endtask

    task automatic test_random();
        int lines [8];
        logic [31:0] a;
        bit wr;
        bit chain;
        int idx;
        for (int i = 0; i < 8; i++) lines[i] = int'($urandom_range(0, (1 << IDX_W) - 1));
        for (int n = 0; n < 40; n++) begin
            idx   = lines[$urandom_range(0, 7)];
            wr    = ($urandom_range(0, 1) == 1) || !model.exists(idx);
            a     = $urandom;
            a[IDX_W+4:5] = idx[IDX_W-1:0];
            chain = (n != 39) && ($urandom_range(0, 1) == 1);
            do_txn(wr, a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   chain, 0);
            if (!chain) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_reset_mid_busy();
        test_hold();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
